// File: rtl/drop_sequencer.sv
// Drop sequencer: counts an 8.8 fall time down in prescaled steps,
// then fires a fixed-width release pulse to the actuator.
module drop_sequencer #(
    parameter int unsigned PRESCALE    = 4,
    parameter logic [15:0] T_MIN       = 16'h0100,
    parameter logic [15:0] T_MAX       = 16'h0F00,
    parameter int unsigned DROP_CYCLES = 3,
    parameter int unsigned ERR_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] t_sqrt,
    output logic        busy,
    output logic        drop_pulse,
    output logic        done,
    output logic        err,
    output logic [15:0] remaining
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DROP,
        ERROR
    } state_t;

    localparam logic [7:0] PS_LAST   = 8'(PRESCALE - 1);
    localparam logic [7:0] DROP_LAST = 8'(DROP_CYCLES - 1);
    localparam logic [7:0] ERR_LAST  = 8'(ERR_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  presc;
    logic [7:0]  presc_nxt;
    logic [7:0]  hold;
    logic [7:0]  hold_nxt;
    logic [15:0] rem_nxt;
    logic        done_nxt;
    logic        in_range;

    assign in_range = (t_sqrt >= T_MIN) && (t_sqrt <= T_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= 8'd0;
            hold       <= 8'd0;
            remaining  <= 16'h0000;
            busy       <= 1'b0;
            drop_pulse <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            hold       <= hold_nxt;
            remaining  <= rem_nxt;
            busy       <= (state_nxt == COUNT) || (state_nxt == DROP);
            drop_pulse <= (state_nxt == DROP);
            done       <= done_nxt;
            err        <= (state_nxt == ERROR);
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        hold_nxt  = hold;
        rem_nxt   = remaining;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            presc_nxt = 8'd0;
            hold_nxt  = 8'd0;
            rem_nxt   = 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        presc_nxt = 8'd0;
                        hold_nxt  = 8'd0;
                        if (in_range) begin
                            state_nxt = COUNT;
                            rem_nxt   = t_sqrt;
                        end else begin
                            state_nxt = ERROR;
                            rem_nxt   = 16'h0000;
                        end
                    end
                end
                COUNT: begin
                    if (presc == PS_LAST) begin
                        presc_nxt = 8'd0;
                        // Saturate at zero; the 1->0 step launches the drop.
                        if (remaining <= 16'd1) begin
                            rem_nxt   = 16'h0000;
                            state_nxt = DROP;
                            hold_nxt  = 8'd0;
                        end else begin
                            rem_nxt = remaining - 16'd1;
                        end
                    end else begin
                        presc_nxt = presc + 8'd1;
                    end
                end
                DROP: begin
                    if (hold == DROP_LAST) begin
                        state_nxt = IDLE;
                        hold_nxt  = 8'd0;
                        done_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold + 8'd1;
                    end
                end
                ERROR: begin
                    if (hold == ERR_LAST) begin
                        state_nxt = IDLE;
                        hold_nxt  = 8'd0;
                    end else begin
                        hold_nxt = hold + 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
